imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
//  Loads a program image into the MIPS instruction memory from a byte stream, replacing $readmemh with hardware.
//  Sits between a byte source (UART RX or host FIFO) and the IM write port; holds the CPU in reset until a load
//  completes and its checksum passes, then releases it.
// PARAMETERS
//  ADDR_W   10   IM word-address width; capacity = 2**ADDR_W words
// PORTS
//  clock        in   1       system clock, rising edge
//  reset        in   1       asynchronous, active-high
//  start        in   1       one-cycle pulse; begins a load when not busy
//  s_data       in   8       stream byte
//  s_valid      in   1       s_data valid
//  s_ready      out  1       loader accepts byte; transfer = s_valid & s_ready at clock edge
//  im_we        out  1       IM write strobe, one cycle per word
//  im_addr      out  ADDR_W  IM word address
//  im_wdata     out  32      IM write data
//  cpu_reset    out  1       reset to mips core; high unless a load succeeded
//  busy         out  1       load in progress
//  done         out  1       last load succeeded (sticky until next start/reset)
//  err          out  1       last load failed (sticky until next start/reset)
//  words_loaded out  ADDR_W+1 words written in current/last load
// BEHAVIOUR
//  Frame: LEN_HI, LEN_LO (16-bit word count N, MSB first), then N words of 4 bytes each, MSB first
//   (matches hex-text order), then 1 checksum byte = sum mod 256 of all 4N word bytes (length excluded).
//  Reset values: s_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_reset=1, busy=0, done=0, err=0,
//   words_loaded=0; FSM in IDLE. Reset mid-load aborts immediately; no im_we after reset asserts.
//  States: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR.
//   IDLE/DONE/ERR --start--> LEN_HI; clears done, err, words_loaded, checksum; cpu_reset=1 next cycle.
//   LEN_HI --byte--> LEN_LO.
//   LEN_LO --byte--> N==0: CHECK; N>2**ADDR_W: ERR; else DATA.
//   DATA: byte counter 0..3 shifts bytes into word register; on 4th byte accepted, next cycle
//    im_we=1, im_addr=word index (0 first), im_wdata=assembled word, words_loaded+1.
//    After word N-1 accepted -> CHECK.
//   CHECK --byte--> DONE if byte==running sum, else ERR.
//  s_ready=1 only in LEN_HI, LEN_LO, DATA, CHECK; 0 in IDLE/DONE/ERR. Loader never stalls a
//   ready state, so s_valid may be held continuously; one byte per clock max throughput.
//  busy=1 in LEN_HI..CHECK. done=1 only in DONE; err=1 only in ERR.
//  cpu_reset=0 only in DONE; registered (glitch-free); goes high the cycle after start leaves DONE.
//  start while busy: ignored. start with s_valid high in same cycle: byte not consumed (s_ready was 0).
//  Failed load leaves written words in IM; CPU stays in reset.
//  Address wrap impossible: N bounded at LEN_LO; N==2**ADDR_W is legal and fills memory exactly.
//  Checksum adder 8-bit, wraps mod 256.
// TESTING
//  1 Reset: assert reset async mid-cycle -> all outputs at reset values same instant, cpu_reset=1.
//  2 Single word: start; bytes 00 01 20 08 00 05 2D -> one im_we, addr 0, data 0x20080005;
//    done=1, cpu_reset=0, words_loaded=1.
//  3 Bad checksum: same frame, last byte 2C -> word still written, err=1, done=0, cpu_reset stays 1.
//  4 Oversize: ADDR_W=10, length 04 01 -> ERR right after LEN_LO, s_ready=0, no im_we.
//  5 Back-pressure/gaps: 3-word frame with random s_valid gaps -> im_addr 0,1,2 in order,
//    data correct, done=1; start pulses during load ignored.
//  6 Zero length + reload: frame 00 00 00 -> DONE, no im_we; then start again -> cpu_reset=1
//    next cycle, done cleared, second frame loads normally.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: fills the MIPS instruction memory from a length-prefixed byte stream.
// The CPU is held in reset until a frame loads and its checksum matches.
module imem_boot_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [1:0]  byte_cnt;
  logic [23:0] word_reg;
  logic [7:0]  checksum;
  logic [15:0] len_in;
  logic        oversize;
  logic        last_word;
  logic        accept;

  assign len_in    = {len_hi, s_data};
  assign oversize  = 32'(len_in) > (32'd1 << ADDR_W);
  assign last_word = (32'(words_loaded) + 32'd1) == 32'(len);
  assign accept    = s_valid & s_ready;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        done = (state == S_DONE);
        err  = (state == S_ERR);
        if (start) next_state = S_LEN_HI;
      end
      S_LEN_HI: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) next_state = S_LEN_LO;
      end
      S_LEN_LO: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          if (len_in == 16'd0)  next_state = S_CHECK;
          else if (oversize)    next_state = S_ERR;
          else                  next_state = S_DATA;
        end
      end
      S_DATA: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid && byte_cnt == 2'd3 && last_word) next_state = S_CHECK;
      end
      S_CHECK: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) next_state = (s_data == checksum) ? S_DONE : S_ERR;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath: length capture, word assembly, IM write strobe and running checksum.
  // words_loaded doubles as the address of the next word to write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_hi       <= '0;
      len          <= '0;
      byte_cnt     <= '0;
      word_reg     <= '0;
      checksum     <= '0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      words_loaded <= '0;
      cpu_reset    <= 1'b1;
    end else begin
      im_we     <= 1'b0;
      cpu_reset <= (next_state != S_DONE);
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            words_loaded <= '0;
            checksum     <= '0;
            byte_cnt     <= '0;
          end
        end
        S_LEN_HI: begin
          if (accept) len_hi <= s_data;
        end
        S_LEN_LO: begin
          if (accept) len <= len_in;
        end
        S_DATA: begin
          if (accept) begin
            checksum <= checksum + s_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              im_we        <= 1'b1;
              im_addr      <= words_loaded[ADDR_W-1:0];
              im_wdata     <= {word_reg, s_data};
              words_loaded <= words_loaded + 1'b1;
            end else begin
              word_reg <= {word_reg[15:0], s_data};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
